pc_fetch_unit: RTL and testbench
================================

# pc_fetch_unit

Instruction-fetch stage of the MIPS pipeline. It owns the architectural PC and issues sequential fetches to instruction memory over a req/ready handshake. It latches each fetched word into the F/D output register and applies branch/jump redirects after the delay slot. Redirect targets arrive from the D-stage next-PC logic, for example the beq target computed as pc + sign-extended imm16 << 2.

## Interface
- RESET_PC, 32'h0000_3000, PC loaded on reset and the first fetch address.
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hazard unit holds D; the F/D register must not change.
- br_take  in  1  taken branch resolved in D (one-cycle pulse, only with stall=0).
- br_target  in  32  branch target.
- j_take  in  1  jump/jr resolved in D (one-cycle pulse, only with stall=0).
- j_target  in  32  jump target.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address (= pc).
- imem_ready  in  1  rdata valid; may assert in the same cycle as req.
- imem_rdata  in  32  instruction word.
- if_valid  out  1  F/D register holds an instruction.
- if_pc  out  32  PC of the held instruction.
- if_instr  out  32  held instruction.
- if_pc8  out  32  if_pc + 8 (link value).
- misalign_err  out  1  sticky: a redirect target had bits [1:0] != 0.

## Operation
- FSM states:
  - IDLE: entered on reset; lasts exactly one cycle after reset_n rises, then goes to RUN.
  - RUN: stays in RUN until reset.
- imem_req = (state==RUN) && (!if_valid || !stall). imem_addr = pc at all times.
- fetch_done = imem_req && imem_ready. On fetch_done:
  - if_instr <= imem_rdata.
  - if_pc <= pc.
  - if_valid <= 1.
  - pc <= next_pc.
- When the D stage consumes (!stall) but no fetch completes, if_valid <= 0 and if_pc/if_instr hold their values.
- When stall=1, if_valid, if_pc and if_instr hold unconditionally.
- Redirect (delay-slot semantics): the redirect is asserted while the branch sits in F/D, so pc already addresses the delay slot.
  - redir = br_take || j_take. tgt = br_take ? br_target : j_target (br wins if both are high).
  - tgt is used with bits [1:0] forced to 00. If the original bits were nonzero, misalign_err <= 1.
  - redir and fetch_done in the same cycle: next_pc = tgt. The delay slot is captured and the next fetch goes to the target.
  - redir without fetch_done: pend_valid <= 1, pend_tgt <= tgt. On the next fetch_done (the delay slot), next_pc = pend_tgt and pend_valid <= 0.
  - redir while pend_valid=1: the new target overwrites pend_tgt (an upstream protocol violation, but behaviour is defined).
  - No redirect and no pending target: next_pc = pc + 4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0000_0000).
- Delay-slot instructions are never squashed.
- if_pc8 = if_pc + 8 (combinational, modulo 2^32).

## Timing
- Reset (asynchronous, immediate on reset_n=0) sets:
  - pc = RESET_PC, state = IDLE.
  - if_valid = 0, if_pc = 0, if_instr = 0.
  - pend_valid = 0, pend_tgt = 0, misalign_err = 0.
- Resulting outputs in reset: imem_req = 0, imem_addr = RESET_PC, if_pc8 = 8.
- A reset asserted mid-fetch or while pend_valid=1 discards all in-flight state.
- First imem_req is in the 2nd cycle after reset_n rises (after IDLE).
- Latency: the instruction returned with imem_ready in cycle N appears on if_valid/if_instr in cycle N+1.
- With ready tied high and stall=0, throughput is one instruction per cycle.
- The redirect target is fetched in the cycle after the delay slot's fetch_done, or in the same cycle as the delay-slot fetch plus one when no wait states occur.
- The misalign_err flag rises in the cycle after the offending redirect and stays high until reset.

## Test plan
- Reset, ready tied 1, stall 0 -> imem_addr sequence 0x3000, 0x3004, 0x3008. if_pc follows one cycle later, and if_pc8 = if_pc + 8.
- br_take with br_target=0x3100 while if_pc=0x3004 and ready=1 -> the next fetches are 0x3008 (delay slot), then 0x3100.
- Same branch with ready=0 for 3 cycles after the pulse -> pend_valid held. The delay slot 0x3008 completes, then the fetch goes to 0x3100. No fetch to 0x300C occurs.
- stall=1 for 4 cycles with if_valid=1 -> imem_req=0, and if_pc/if_instr are unchanged. Fetching resumes at the same pc when stall drops.
- j_take with j_target=0x0000_3202 -> the fetch goes to 0x3200 and misalign_err=1 until reset. Separately, pc=0xFFFF_FFFC sequential -> the next address is 0x0000_0000.
- reset_n pulsed low mid-fetch with pend_valid=1 -> all outputs return to their reset values immediately, and the first fetch after release is 0x3000.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, issues fetches over a req/ready handshake,
// holds the F/D register and applies branch/jump redirects after the delay slot.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        br_take,
  input  logic [31:0] br_target,
  input  logic        j_take,
  input  logic [31:0] j_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc8,
  output logic        misalign_err
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, next_pc;
  logic        if_valid_reg;
  logic [31:0] if_pc_reg, if_instr_reg;
  logic        pend_valid_reg;
  logic [31:0] pend_tgt_reg;
  logic        misalign_reg;
  logic        fetch_done;
  logic        redir;
  logic [31:0] tgt_raw, tgt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  // IDLE is a single settling cycle; fetching starts once in RUN.
  always_comb begin
    state_next = state_reg;
    imem_req   = 1'b0;
    case (state_reg)
      IDLE: state_next = RUN;
      RUN: begin
        state_next = RUN;
        imem_req   = !if_valid_reg || !stall;
      end
      default: state_next = IDLE;
    endcase
  end

  assign fetch_done = imem_req && imem_ready;
  assign redir      = br_take || j_take;
  assign tgt_raw    = br_take ? br_target : j_target;
  assign tgt        = {tgt_raw[31:2], 2'b00};

  // A redirect seen with the delay-slot fetch steers the following fetch;
  // otherwise a pending target waits for the delay slot to complete.
  always_comb begin
    if (redir)               next_pc = tgt;
    else if (pend_valid_reg) next_pc = pend_tgt_reg;
    else                     next_pc = pc_reg + 32'd4;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_reg         <= RESET_PC;
      if_valid_reg   <= 1'b0;
      if_pc_reg      <= 32'h0;
      if_instr_reg   <= 32'h0;
      pend_valid_reg <= 1'b0;
      pend_tgt_reg   <= 32'h0;
      misalign_reg   <= 1'b0;
    end else begin
      if (fetch_done) begin
        if_instr_reg   <= imem_rdata;
        if_pc_reg      <= pc_reg;
        if_valid_reg   <= 1'b1;
        pc_reg         <= next_pc;
        pend_valid_reg <= 1'b0;
      end else begin
        if (!stall) if_valid_reg <= 1'b0;
        if (redir) begin
          pend_valid_reg <= 1'b1;
          pend_tgt_reg   <= tgt;
        end
      end
      if (redir && (tgt_raw[1:0] != 2'b00)) misalign_reg <= 1'b1;
    end
  end

  assign imem_addr    = pc_reg;
  assign if_valid     = if_valid_reg;
  assign if_pc        = if_pc_reg;
  assign if_instr     = if_instr_reg;
  assign if_pc8       = if_pc_reg + 32'd8;
  assign misalign_err = misalign_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_pc_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        br_take = 1'b0;
  logic [31:0] br_target = 32'h0;
  logic        j_take = 1'b0;
  logic [31:0] j_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic [31:0] if_pc8;
  logic        misalign_err;

  pc_fetch_unit dut (
    .clk(clk), .reset_n(reset_n), .stall(stall),
    .br_take(br_take), .br_target(br_target),
    .j_take(j_take), .j_target(j_target),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr),
    .if_pc8(if_pc8), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model: architectural PC, F/D contents, pending redirect.
  logic        m_started, m_v, m_pend, m_mis;
  logic [31:0] m_pc, m_ifpc, m_instr, m_ptgt;
  // Snapshot of DUT outputs taken at the last compare point.
  logic        s_req, s_v, s_mis;
  logic [31:0] s_addr, s_ifpc, s_instr, s_pc8;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_started = 1'b0; m_v = 1'b0; m_pend = 1'b0; m_mis = 1'b0;
    m_pc = 32'h0000_3000; m_ifpc = 32'h0; m_instr = 32'h0; m_ptgt = 32'h0;
  endtask

  // One clock: drive inputs, compare against the model, then advance the model.
  task automatic cycle(input logic s, input logic bt, input logic [31:0] btg,
                       input logic jt, input logic [31:0] jtg, input logic rdy);
    logic        e_req, fd, redir;
    logic [31:0] tgt;
    @(negedge clk);
    stall = s; br_take = bt; br_target = btg; j_take = jt; j_target = jtg;
    imem_ready = rdy;
    imem_rdata = rdy ? mem(m_pc) : $urandom;
    #1;
    e_req = m_started && reset_n && (!m_v || !s);
    s_req = imem_req; s_addr = imem_addr; s_v = if_valid; s_ifpc = if_pc;
    s_instr = if_instr; s_pc8 = if_pc8; s_mis = misalign_err;
    chk("imem_req", {31'b0, s_req}, {31'b0, e_req});
    chk("imem_addr", s_addr, m_pc);
    chk("if_valid", {31'b0, s_v}, {31'b0, m_v});
    chk("if_pc", s_ifpc, m_ifpc);
    chk("if_instr", s_instr, m_instr);
    chk("if_pc8", s_pc8, m_ifpc + 32'd8);
    chk("misalign_err", {31'b0, s_mis}, {31'b0, m_mis});
    $display("cyc t=%0t rst_n=%0b stall=%0b br=%0b j=%0b rdy=%0b req=%0b addr=%08h v=%0b if_pc=%08h mis=%0b",
             $time, reset_n, s, bt, jt, rdy, s_req, s_addr, s_v, s_ifpc, s_mis);
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      fd    = e_req && rdy;
      redir = bt || jt;
      tgt   = bt ? btg : jtg;
      if (redir && tgt[1:0] != 2'b00) m_mis = 1'b1;
      tgt[1:0] = 2'b00;
      if (fd) begin
        m_instr = imem_rdata;
        m_ifpc  = m_pc;
        m_v     = 1'b1;
        m_pc    = redir ? tgt : (m_pend ? m_ptgt : m_pc + 32'd4);
        m_pend  = 1'b0;
      end else begin
        if (!s) m_v = 1'b0;
        if (redir) begin
          m_pend = 1'b1;
          m_ptgt = tgt;
        end
      end
      m_started = 1'b1;
    end
  endtask

  task automatic run(input logic rdy);
    cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy);
  endtask

  // Asynchronous reset: outputs must clear immediately, before any clock edge.
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst imem_req", {31'b0, imem_req}, 32'h0);
    chk("rst imem_addr", imem_addr, 32'h0000_3000);
    chk("rst if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst if_pc", if_pc, 32'h0);
    chk("rst if_instr", if_instr, 32'h0);
    chk("rst if_pc8", if_pc8, 32'h8);
    chk("rst misalign_err", {31'b0, misalign_err}, 32'h0);
    model_reset();
    run(1'b1);
    run(1'b1);
    #2;
    reset_n = 1'b1;
  endtask

  initial begin
    logic s, bt, jt, rdy;
    logic [31:0] tg;
    model_reset();

    // Sequential fetch and branch taken with the delay slot completing at once.
    do_reset();
    run(1'b1); chk("idle no req", {31'b0, s_req}, 32'h0);
    run(1'b1); chk("first addr", s_addr, 32'h0000_3000);
    chk("first req", {31'b0, s_req}, 32'h1);
    run(1'b1); chk("addr 3004", s_addr, 32'h0000_3004); chk("if_pc 3000", s_ifpc, 32'h0000_3000);
    cycle(1'b0, 1'b1, 32'h0000_3100, 1'b0, 32'h0, 1'b1);
    chk("delay slot addr", s_addr, 32'h0000_3008); chk("if_pc8 300c", s_pc8, 32'h0000_300C);
    run(1'b1); chk("branch tgt", s_addr, 32'h0000_3100); chk("if_pc slot", s_ifpc, 32'h0000_3008);

    // Branch with wait states: target pends until the delay slot completes.
    do_reset();
    run(1'b1); run(1'b1); run(1'b1);
    cycle(1'b0, 1'b1, 32'h0000_3100, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      run(1'b0); chk("wait addr", s_addr, 32'h0000_3008);
    end
    run(1'b1); chk("slot fetch", s_addr, 32'h0000_3008);
    run(1'b1); chk("pend tgt", s_addr, 32'h0000_3100);

    // Stall holds the F/D register and blocks fetching.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
      chk("stall req", {31'b0, s_req}, 32'h0);
      chk("stall if_pc", s_ifpc, 32'h0000_3100);
      chk("stall instr", s_instr, mem(32'h0000_3100));
    end
    run(1'b1); chk("resume addr", s_addr, 32'h0000_3104);

    // Misaligned jump target, then wrap-around at the top of memory.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_3202, 1'b1);
    run(1'b1); chk("jump tgt", s_addr, 32'h0000_3200); chk("misalign set", {31'b0, s_mis}, 32'h1);
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8, 1'b1);
    run(1'b1); chk("addr fff8", s_addr, 32'hFFFF_FFF8);
    run(1'b1); chk("addr fffc", s_addr, 32'hFFFF_FFFC);
    run(1'b1); chk("wrap addr", s_addr, 32'h0000_0000);
    chk("misalign sticky", {31'b0, s_mis}, 32'h1);
    chk("if_pc8 wrap", s_pc8, 32'h0000_0004);

    // Reset while a redirect is pending discards it.
    cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0000_4000, 1'b0);
    do_reset();
    run(1'b1); chk("post rst idle", {31'b0, s_req}, 32'h0);
    run(1'b1); chk("post rst addr", s_addr, 32'h0000_3000);

    // Randomized traffic; redirects only while D holds an unstalled instruction.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        continue;
      end
      rdy = ($urandom_range(0, 9) < 7);
      s   = m_v && ($urandom_range(0, 9) < 3);
      bt  = 1'b0; jt = 1'b0;
      if (m_v && !s && $urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 1) bt = 1'b1;
        if ($urandom_range(0, 2) == 0) jt = 1'b1;
        if (!bt) jt = 1'b1;
      end
      tg = $urandom;
      if ($urandom_range(0, 7) != 0) tg[1:0] = 2'b00;
      cycle(s, bt, tg, jt, ~tg, rdy);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
